// File: rtl/seq_divider_if.sv
// Handshake and operand/result bundle for the sequential divider.
//
// Signals:
//   start       request, sampled only while busy is low
//   is_signed   1 = two's-complement divide, 0 = unsigned
//   dividend    dividend operand
//   divisor     divisor operand
//   busy        operation in progress
//   done        one-cycle completion pulse
//   div_by_zero divisor was zero for the completed operation
//   quotient    final quotient, held until the next completion
//   remainder   final remainder, held until the next completion
//
// Modports: master = requester (control unit / bench), slave = divider.
interface seq_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, div_by_zero, quotient, remainder
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, div_by_zero, quotient, remainder
  );
endinterface

// File: rtl/seq_divider.sv
// Sequential non-restoring divider producing quotient and remainder for
// signed (truncating) and unsigned operands. One quotient bit is resolved
// per clock, giving a fixed latency of WIDTH+1 edges from the accepting
// edge to the edge that raises done. Results and the divide-by-zero flag
// are held until the next operation completes.
//
// Ports:
//   clk     clock, all state updates on the rising edge
//   resetn  synchronous, active-low reset
//   bus     seq_divider_if slave modport (start/is_signed/dividend/divisor
//           in; busy/done/div_by_zero/quotient/remainder out)
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        resetn,
  seq_divider_if.slave bus
);

  localparam int                CNT_W     = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Absolute value of an operand; the most-negative value maps onto
  // 2^(WIDTH-1) when read back as unsigned, which is what the core needs.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic             sgn);
    return (sgn && v[WIDTH-1]) ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                  input logic             neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  // Control state (reset)
  state_t           state_q, state_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;

  // Datapath state (only meaningful while busy, never reset)
  logic signed [WIDTH:0] a_q, a_d;
  logic [WIDTH-1:0]      q_q, q_d;
  logic [WIDTH-1:0]      dvs_q, dvs_d;
  logic [WIDTH-1:0]      dvd_q, dvd_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  neg_quo_q, neg_quo_d;
  logic                  neg_rem_q, neg_rem_d;
  logic                  dbz_q, dbz_d;

  logic signed [WIDTH:0] a_sh;
  logic signed [WIDTH:0] a_new;
  logic [WIDTH-1:0]      rem_mag;

  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    dz_d      = dz_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    a_d       = a_q;
    q_d       = q_q;
    dvs_d     = dvs_q;
    dvd_d     = dvd_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dbz_d     = dbz_q;
    // The top bit of A is discarded by the shift; arithmetic is modulo
    // 2^(WIDTH+1) and the post-add/sub value always fits back into range.
    a_sh      = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
    a_new     = a_sh;
    rem_mag   = a_q[WIDTH-1:0];

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = CALC;
          neg_quo_d = bus.is_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
          neg_rem_d = bus.is_signed & bus.dividend[WIDTH-1];
          dbz_d     = (bus.divisor == '0);
          dvd_d     = bus.dividend;
          dvs_d     = magnitude(bus.divisor, bus.is_signed);
          q_d       = magnitude(bus.dividend, bus.is_signed);
          a_d       = '0;
          cnt_d     = '0;
        end
      end

      CALC: begin
        if (!a_q[WIDTH]) begin
          a_new = a_sh - $signed({1'b0, dvs_q});
        end else begin
          a_new = a_sh + $signed({1'b0, dvs_q});
        end
        a_d   = a_new;
        q_d   = {q_q[WIDTH-2:0], ~a_new[WIDTH]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          state_d = FIX;
        end
      end

      FIX: begin
        // A negative partial remainder is one divisor short of the true one.
        rem_mag = a_q[WIDTH] ? (a_q[WIDTH-1:0] + dvs_q) : a_q[WIDTH-1:0];
        if (dbz_q) begin
          quo_d = '1;
          rem_d = dvd_q;
          dz_d  = 1'b1;
        end else begin
          quo_d = apply_sign(q_q, neg_quo_q);
          rem_d = apply_sign(rem_mag, neg_rem_q);
          dz_d  = 1'b0;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
    end
  end

  always_ff @(posedge clk) begin
    a_q       <= a_d;
    q_q       <= q_d;
    dvs_q     <= dvs_d;
    dvd_q     <= dvd_d;
    cnt_q     <= cnt_d;
    neg_quo_q <= neg_quo_d;
    neg_rem_q <= neg_rem_d;
    dbz_q     <= dbz_d;
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dz_q;
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  seq_divider_if #(.WIDTH(32)) b32();
  seq_divider_if #(.WIDTH(8))  b8();

  seq_divider #(.WIDTH(32)) u32 (.clk(clk), .resetn(resetn), .bus(b32.slave));
  seq_divider #(.WIDTH(8))  u8  (.clk(clk), .resetn(resetn), .bus(b8.slave));

  // Issue one 32-bit operation and wait for done; lat counts edges after
  // the accepting edge, busy_ok records that busy stayed high until done.
  task automatic op32(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                      output logic [31:0] q, output logic [31:0] r,
                      output logic dz, output int lat, output logic busy_ok);
    @(negedge clk);
    b32.start = 1'b1; b32.is_signed = sgn; b32.dividend = a; b32.divisor = b;
    @(posedge clk); #1;
    b32.start = 1'b0;
    lat = 0; busy_ok = 1'b1;
    while (!b32.done && lat < 100) begin
      if (!b32.busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    q = b32.quotient; r = b32.remainder; dz = b32.div_by_zero;
  endtask

  task automatic op8(input logic sgn, input logic [7:0] a, input logic [7:0] b,
                     output logic [7:0] q, output logic [7:0] r, output int lat);
    @(negedge clk);
    b8.start = 1'b1; b8.is_signed = sgn; b8.dividend = a; b8.divisor = b;
    @(posedge clk); #1;
    b8.start = 1'b0;
    lat = 0;
    while (!b8.done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    q = b8.quotient; r = b8.remainder;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    b32.start = 1'b0; b32.is_signed = 1'b0; b32.dividend = '0; b32.divisor = '0;
    b8.start = 1'b0;  b8.is_signed = 1'b0;  b8.dividend = '0;  b8.divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({b32.busy, b32.done, b32.div_by_zero} !== 3'b000 ||
        b32.quotient !== 32'd0 || b32.remainder !== 32'd0) begin
      errors++;
      $display("FAIL reset32: busy/done/dz=%b q=%h r=%h, want 000 0 0",
               {b32.busy, b32.done, b32.div_by_zero}, b32.quotient, b32.remainder);
    end
    checks++;
    if ({b8.busy, b8.done, b8.div_by_zero} !== 3'b000 ||
        b8.quotient !== 8'd0 || b8.remainder !== 8'd0) begin
      errors++;
      $display("FAIL reset8: busy/done/dz=%b q=%h r=%h, want 000 0 0",
               {b8.busy, b8.done, b8.div_by_zero}, b8.quotient, b8.remainder);
    end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_unsigned();
    logic [31:0] q, r; logic dz, bok; int lat;
    op32(1'b0, 32'd38, 32'd6, q, r, dz, lat, bok);
    checks++;
    if (q !== 32'd6 || r !== 32'd2 || dz !== 1'b0) begin
      errors++;
      $display("FAIL u38_6: q=%0d r=%0d dz=%b, want 6 2 0", q, r, dz);
    end
    checks++;
    if (lat !== 33) begin
      errors++;
      $display("FAIL u38_6_latency: got %0d edges, want 33", lat);
    end
    checks++;
    if (bok !== 1'b1) begin
      errors++;
      $display("FAIL u38_6_busy: busy dropped before done, got %b want 1", bok);
    end
    checks++;
    if (b32.busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_at_done: got %b want 0", b32.busy);
    end
    @(posedge clk); #1;
    checks++;
    if (b32.done !== 1'b0 || b32.quotient !== 32'd6 || b32.remainder !== 32'd2) begin
      errors++;
      $display("FAIL done_pulse_hold: done=%b q=%0d r=%0d, want 0 6 2",
               b32.done, b32.quotient, b32.remainder);
    end
    op32(1'b0, 32'hFFFF_FFFF, 32'd2, q, r, dz, lat, bok);
    checks++;
    if (q !== 32'h7FFF_FFFF || r !== 32'd1) begin
      errors++;
      $display("FAIL uFFFFFFFF_2: q=%h r=%h, want 7fffffff 1", q, r);
    end
  endtask

  task automatic test_signed();
    logic [31:0] q, r; logic dz, bok; int lat;
    op32(1'b1, -32'sd38, 32'd6, q, r, dz, lat, bok);
    checks++;
    if (q !== 32'hFFFF_FFFA || r !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL s-38_6: q=%h r=%h, want fffffffa fffffffe", q, r);
    end
    op32(1'b1, 32'd38, -32'sd6, q, r, dz, lat, bok);
    checks++;
    if (q !== 32'hFFFF_FFFA || r !== 32'd2) begin
      errors++;
      $display("FAIL s38_-6: q=%h r=%h, want fffffffa 2", q, r);
    end
    op32(1'b1, -32'sd38, -32'sd6, q, r, dz, lat, bok);
    checks++;
    if (q !== 32'd6 || r !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL s-38_-6: q=%h r=%h, want 6 fffffffe", q, r);
    end
  endtask

  task automatic test_div_by_zero();
    logic [31:0] q, r; logic dz, bok; int lat;
    op32(1'b0, 32'd100, 32'd0, q, r, dz, lat, bok);
    checks++;
    if (q !== 32'hFFFF_FFFF || r !== 32'd100 || dz !== 1'b1) begin
      errors++;
      $display("FAIL dbz100: q=%h r=%0d dz=%b, want ffffffff 100 1", q, r, dz);
    end
    checks++;
    if (lat !== 33) begin
      errors++;
      $display("FAIL dbz_latency: got %0d edges, want 33", lat);
    end
    op32(1'b0, 32'd100, 32'd25, q, r, dz, lat, bok);
    checks++;
    if (q !== 32'd4 || r !== 32'd0 || dz !== 1'b0) begin
      errors++;
      $display("FAIL u100_25: q=%0d r=%0d dz=%b, want 4 0 0", q, r, dz);
    end
    op32(1'b1, -32'sd5, 32'd0, q, r, dz, lat, bok);
    checks++;
    if (q !== 32'hFFFF_FFFF || r !== 32'hFFFF_FFFB || dz !== 1'b1) begin
      errors++;
      $display("FAIL dbz_signed: q=%h r=%h dz=%b, want ffffffff fffffffb 1", q, r, dz);
    end
  endtask

  task automatic test_boundary();
    logic [31:0] q, r; logic dz, bok; int lat;
    op32(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, q, r, dz, lat, bok);
    checks++;
    if (q !== 32'h8000_0000 || r !== 32'd0 || dz !== 1'b0) begin
      errors++;
      $display("FAIL s_overflow: q=%h r=%h dz=%b, want 80000000 0 0", q, r, dz);
    end
    op32(1'b0, 32'h7FFF_FFFF, 32'd1, q, r, dz, lat, bok);
    checks++;
    if (q !== 32'h7FFF_FFFF || r !== 32'd0) begin
      errors++;
      $display("FAIL u7fffffff_1: q=%h r=%h, want 7fffffff 0", q, r);
    end
    op32(1'b0, 32'd1, 32'd50, q, r, dz, lat, bok);
    checks++;
    if (q !== 32'd0 || r !== 32'd1) begin
      errors++;
      $display("FAIL u1_50: q=%0d r=%0d, want 0 1", q, r);
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    @(negedge clk);
    b32.start = 1'b1; b32.is_signed = 1'b0; b32.dividend = 32'd38; b32.divisor = 32'd6;
    @(posedge clk); #1;
    b32.start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    b32.start = 1'b1; b32.dividend = 32'd7; b32.divisor = 32'd7;
    @(posedge clk); #1;
    b32.start = 1'b0;
    lat = 6;
    while (!b32.done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (b32.quotient !== 32'd6 || b32.remainder !== 32'd2 || lat !== 33) begin
      errors++;
      $display("FAIL ignore_start: q=%0d r=%0d lat=%0d, want 6 2 33",
               b32.quotient, b32.remainder, lat);
    end
  endtask

  task automatic test_abort_reset();
    int seen;
    @(negedge clk);
    b32.start = 1'b1; b32.is_signed = 1'b0; b32.dividend = 32'd38; b32.divisor = 32'd6;
    @(posedge clk); #1;
    b32.start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    resetn = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({b32.busy, b32.done, b32.div_by_zero} !== 3'b000 ||
        b32.quotient !== 32'd0 || b32.remainder !== 32'd0) begin
      errors++;
      $display("FAIL abort_reset: busy/done/dz=%b q=%h r=%h, want 000 0 0",
               {b32.busy, b32.done, b32.div_by_zero}, b32.quotient, b32.remainder);
    end
    resetn = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (b32.done || b32.busy) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL abort_no_done: %0d cycles with done/busy after reset, want 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] q, r; int lat;
    op8(1'b0, 8'd200, 8'd7, q, r, lat);
    checks++;
    if (q !== 8'd28 || r !== 8'd4 || lat !== 9) begin
      errors++;
      $display("FAIL w8_200_7: q=%0d r=%0d lat=%0d, want 28 4 9", q, r, lat);
    end
    // still in the done cycle: issue the next request immediately
    b8.start = 1'b1; b8.is_signed = 1'b1; b8.dividend = 8'h80; b8.divisor = 8'd3;
    @(posedge clk); #1;
    b8.start = 1'b0;
    checks++;
    if (b8.busy !== 1'b1 || b8.quotient !== 8'd28 || b8.remainder !== 8'd4) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b q=%0d r=%0d, want 1 28 4",
               b8.busy, b8.quotient, b8.remainder);
    end
    lat = 0;
    while (!b8.done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (b8.quotient !== 8'hD6 || b8.remainder !== 8'hFE || lat !== 9) begin
      errors++;
      $display("FAIL b2b_s-128_3: q=%h r=%h lat=%0d, want d6 fe 9",
               b8.quotient, b8.remainder, lat);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_by_zero();
    test_boundary();
    test_ignore_start();
    test_abort_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Parametrised sequential non-restoring divider for the ALU datapath, producing quotient and remainder for the DIV/DIVU-class instructions.
- Supports signed (truncating) and unsigned operation.
- Uses a start/done handshake with a busy flag and a fixed latency of WIDTH+1 clock edges.
- Detects divide-by-zero.
- Results are held stable after completion so the control unit can latch them into HI/LO (Z[63:32]/Z[31:0]) at any later cycle.

Parameters:
WIDTH, 32, operand/result width in bits; legal values 4..64.

Ports:
clk  in  1  clock; all state updates on rising edge.
resetn  in  1  synchronous, active-low reset.
start  in  1  request; sampled only while busy=0.
is_signed  in  1  1 = two's-complement divide, 0 = unsigned; sampled with start.
dividend  in  WIDTH  dividend; sampled with start.
divisor  in  WIDTH  divisor; sampled with start.
busy  out  1  high from the edge accepting start until the edge that raises done.
done  out  1  one-cycle pulse; results valid from this cycle onward.
div_by_zero  out  1  set with done when divisor==0; held with the results.
quotient  out  WIDTH  final quotient.
remainder  out  WIDTH  final remainder.

Behaviour:
- Reset (resetn=0 at an edge): state=IDLE; busy, done, div_by_zero, quotient and remainder all 0. Reset overrides everything, including an operation in progress, which is abandoned with no done pulse.
- States: IDLE -> CALC -> FIX -> IDLE.
- IDLE, start=1 at edge E0:
  - Latch sign flags: neg_q = is_signed & (dividend[MSB] ^ divisor[MSB]); neg_r = is_signed & dividend[MSB].
  - Latch dbz = (divisor==0).
  - Latch magnitudes |dividend| and |divisor| (two's-complement negate when is_signed and MSB=1; the most-negative value maps to 2^(WIDTH-1) as unsigned).
  - Load A=0 (WIDTH+1 bits, signed) and Q=|dividend|; clear counter; go to CALC; busy=1.
- CALC, one iteration per edge for exactly WIDTH edges (E1..E_WIDTH):
  - Shift {A,Q} left 1.
  - If A was non-negative before the shift, A -= |divisor|; otherwise A += |divisor|.
  - Set Q[0] = ~A[MSB] (new A).
  - After WIDTH iterations go to FIX.
- FIX, edge E_WIDTH+1:
  - If A<0, A += |divisor| (remainder restore).
  - quotient = neg_q ? -Q : Q; remainder = neg_r ? -A[WIDTH-1:0] : A[WIDTH-1:0].
  - If dbz: quotient = all ones, remainder = original dividend, div_by_zero=1; otherwise div_by_zero=0.
  - Set done=1 and busy=0; go to IDLE.
- Total latency: done is high in the cycle following edge E0+WIDTH+1. The latency is fixed, with no early termination, including for divide-by-zero.
- done deasserts at the next edge. quotient, remainder and div_by_zero hold until the next accepted start, at which point they are left unchanged until the next FIX.
- start while busy=1 is ignored entirely; operand changes during CALC have no effect.
- start in the same cycle as done (IDLE after FIX) is accepted normally (back-to-back operation).
- Signed overflow: most-negative / -1 gives quotient = most-negative and remainder = 0, with no flag.
- Sign rules: quotient truncates toward zero; the remainder takes the dividend's sign; |remainder| < |divisor|.
- Unsigned mode treats all WIDTH bits as magnitude (e.g. 0xFFFFFFFF / 2 = 0x7FFFFFFF r 1).

Test Plan:
1. WIDTH=32, unsigned 38/6 -> quotient=6, remainder=2, div_by_zero=0; done exactly 33 edges after the start edge; busy high for that whole interval.
2. Signed -38/6 -> quotient=0xFFFFFFFA, remainder=0xFFFFFFFE. Signed 38/-6 -> quotient=0xFFFFFFFA, remainder=2. Signed -38/-6 -> quotient=6, remainder=0xFFFFFFFE.
3. Unsigned 100/0 -> quotient=0xFFFFFFFF, remainder=100, div_by_zero=1 with the same 33-edge latency; a following 100/25 clears div_by_zero and gives quotient=4, remainder=0.
4. Signed 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0. Unsigned 0x7FFFFFFF/1 -> quotient=0x7FFFFFFF, remainder=0. Unsigned 1/50 -> quotient=0, remainder=1.
5. Start 38/6, then:
   - Pulse start with 7/7 at iteration 5 -> ignored; the result is still 6 r 2.
   - Assert resetn=0 at iteration 10 of a fresh operation -> next cycle busy=0, done=0, all outputs 0, and no done pulse follows.
6. WIDTH=8 instance, unsigned 200/7 -> quotient=28, remainder=4, done 9 edges after start. Issue back-to-back starts in the done cycle (signed -128/3 -> quotient=0xD6, remainder=0xFE) and check both results.
